rect_fill: RTL and testbench
============================

# rect_fill

Parametrised rectangle fill engine driving the VGA adapter's pixel-plot port; generalises the full-screen fill to an arbitrary clipped rectangle with selectable colour patterns. It sits between a control FSM issuing fill commands and the VGA adapter (`vga_x`, `vga_y`, `vga_colour`, `vga_plot`). It emits one pixel per clock in column-major order: y is the inner loop, x the outer loop.

## Interface
- `SCREEN_W`, default 160: screen width in pixels.
- `SCREEN_H`, default 120: screen height in pixels.
- `X_W`, default 8: x coordinate width; must satisfy 2^X_W >= SCREEN_W + 1.
- `Y_W`, default 7: y coordinate width; must satisfy 2^Y_W >= SCREEN_H + 1.
- `COLOUR_W`, default 3: colour width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command request/hold.
- `x0`  in  X_W  rectangle left edge.
- `y0`  in  Y_W  rectangle top edge.
- `w`  in  X_W  rectangle width in pixels.
- `h`  in  Y_W  rectangle height in pixels.
- `mode`  in  2  colour pattern select.
- `colour`  in  COLOUR_W  base colour.
- `busy`  out  1  fill in progress.
- `done`  out  1  fill complete; held while `start` is high.
- `vga_x`  out  X_W  pixel x.
- `vga_y`  out  Y_W  pixel y.
- `vga_colour`  out  COLOUR_W  pixel colour.
- `vga_plot`  out  1  pixel write strobe.

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: when `start` is 1, capture `x0`, `y0`, `mode`, `colour`, and the clipped bounds; then go to FILL.
  - Clipped bounds: `xe = min(x0+w, SCREEN_W)`, `ye = min(y0+h, SCREEN_H)`. Compute at X_W+1 / Y_W+1 bits so the sum cannot overflow.
  - If the rectangle is empty (`w==0`, `h==0`, `x0>=SCREEN_W`, or `y0>=SCREEN_H`), go directly to DONE with no plots.
- FILL: each cycle output the current (x,y) with `vga_plot`=1.
  - If `y+1<ye`, then y++.
  - Otherwise, y=y0 and x++.
  - When x==xe-1 and y==ye-1, go to DONE after this pixel is plotted.
- DONE: `done`=1, `vga_plot`=0. Stay while `start`=1; return to IDLE when `start`=0.
- Inputs other than `start` are ignored outside IDLE.
- Colour by captured `mode`:
  - 0: solid `colour`.
  - 1: `x mod 2^COLOUR_W` (legacy column stripes; `colour` is ignored).
  - 2: `y mod 2^COLOUR_W`.
  - 3: checkerboard, `colour` when `x[0]^y[0]==0`, else `~colour`.
- `busy`=1 only in FILL.

## Timing
- Reset (any state, including mid-fill): state becomes IDLE. `vga_plot`, `done` and `busy` become 0; `vga_x`, `vga_y` and `vga_colour` become 0. Reset takes priority over `start`.
- Outputs are registered. If `start` is sampled high in IDLE at edge N, the first pixel (x0,y0) is valid with `vga_plot`=1 after edge N+1.
- A clipped rectangle of cw×ch pixels takes exactly cw·ch consecutive plot cycles, with no bubbles.
- `done` rises on the edge after the last plot. For an empty rectangle, `done` rises at edge N+1 and `vga_plot` never asserts.
- `done` falls on the edge after `start` is sampled low. A new command is accepted no earlier than the following edge.
- `vga_x`, `vga_y` and `vga_colour` hold their last values in DONE and IDLE.

## Configuration
- `RECT_FILL_PAUSE_EN` defined: adds input `pause` (1 bit).
  - While `pause`=1 in FILL, the scan position freezes and `vga_plot`=0.
  - Scan resumes on the same pixel the cycle after `pause` falls.
  - Total plot count is unchanged; `pause` is ignored in IDLE and DONE.
- Not defined: there is no `pause` port, and FILL never stalls.

## Test plan
- Full screen: `x0`=0, `y0`=0, `w`=160, `h`=120, `mode`=1 -> 19200 consecutive plots; y runs 0..119 inside x 0..159; colour = x%8; `done`=1 on the following cycle.
- Small rectangle: `x0`=10, `y0`=20, `w`=3, `h`=2, `mode`=0, `colour`=5 -> plots in the order (10,20), (10,21), (11,20), (11,21), (12,20), (12,21), all colour 5; then `done`.
- Clipping: `x0`=158, `y0`=118, `w`=5, `h`=5, `mode`=3, `colour`=2 -> exactly 4 plots: (158,118)=2, (158,119)=5, (159,118)=5, (159,119)=2.
- Empty command: `w`=0 -> `done`=1 one cycle after `start`, zero plots. `start` held 5 cycles -> `done` stays 1; `start` dropped -> `done`=0 next cycle.
- Reset mid-fill: assert `rst` during the 50th pixel of a full-screen fill -> next cycle all outputs 0 and state IDLE; a new `start` restarts at (x0,y0).
- With `RECT_FILL_PAUSE_EN`: `pause` held 3 cycles mid-fill -> `vga_plot`=0 for 3 cycles, no pixel skipped or repeated, total plot count unchanged.

Source files
------------

// File: rtl/rect_fill.sv
// rect_fill: clipped rectangle pixel-plot engine for the VGA adapter, column-major scan.
// Optional RECT_FILL_PAUSE_EN adds a pause input that stalls the scan.
module rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [1:0]          mode,
  input  logic [COLOUR_W-1:0] colour,
`ifdef RECT_FILL_PAUSE_EN
  input  logic                pause,
`endif
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam logic [X_W:0] XS = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] YS = (Y_W+1)'(SCREEN_H);
  state_t state, state_n;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y, ys;
  logic [X_W:0] xe, xsum, xe_n;
  logic [Y_W:0] ye, ysum, ye_n;
  logic [1:0] md;
  logic [COLOUR_W-1:0] col, pix;
  logic empty, y_wrap, last, stall;
`ifdef RECT_FILL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif
  // Sums are one bit wider than the coordinates so x0+w cannot wrap before clipping.
  always_comb begin
    xsum = {1'b0, x0} + {1'b0, w};
    ysum = {1'b0, y0} + {1'b0, h};
    xe_n = (xsum > XS) ? XS : xsum;
    ye_n = (ysum > YS) ? YS : ysum;
    empty = (w == '0) || (h == '0) || ({1'b0, x0} >= XS) || ({1'b0, y0} >= YS);
    y_wrap = ({1'b0, y} + 1'b1) >= ye;
    last = y_wrap && (({1'b0, x} + 1'b1) == xe);
  end
  always_comb begin
    state_n = (state == IDLE) ? (start ? (empty ? DONE : FILL) : IDLE) :
              (state == FILL) ? ((last && !stall) ? DONE : FILL) :
              (start ? DONE : IDLE);
  end
  always_comb begin
    busy = state == FILL;
    pix = (md == 2'd0) ? col :
          (md == 2'd1) ? COLOUR_W'(x) :
          (md == 2'd2) ? COLOUR_W'(y) :
          ((x[0] ^ y[0]) ? ~col : col);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      x          <= '0;
      y          <= '0;
      ys         <= '0;
      xe         <= '0;
      ye         <= '0;
      md         <= '0;
      col        <= '0;
    end else begin
      state    <= state_n;
      done     <= state == DONE;
      vga_plot <= (state == FILL) && !stall;
      if (state == IDLE && start) begin
        x   <= x0;
        y   <= y0;
        ys  <= y0;
        xe  <= xe_n;
        ye  <= ye_n;
        md  <= mode;
        col <= colour;
      end
      if (state == FILL && !stall) begin
        vga_x      <= x;
        vga_y      <= y;
        vga_colour <= pix;
        x          <= y_wrap ? x + 1'b1 : x;
        y          <= y_wrap ? ys : y + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: randomized and directed fills checked against a loop-based pixel list model.
module tb_rect_fill;
  logic clk = 0, rst = 1, start = 0, pause = 0;
  logic [7:0] x0 = 0, w = 0;
  logic [6:0] y0 = 0, h = 0;
  logic [1:0] mode = 0;
  logic [2:0] colour = 0;
  logic busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int n_checks = 0, n_err = 0;
  int exp_q[$];
  bit pause_en;

  always #5 clk = ~clk;

  rect_fill dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .mode(mode), .colour(colour), .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
`ifdef RECT_FILL_PAUSE_EN
    , .pause(pause)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {14'd0, vga_x, vga_y, vga_colour};
  endfunction

  task automatic model(input int ax0, ay0, aw, ah, am, ac);
    int xe, ye, c;
    exp_q.delete();
    xe = (ax0 + aw > 160) ? 160 : ax0 + aw;
    ye = (ay0 + ah > 120) ? 120 : ay0 + ah;
    for (int xx = ax0; xx < xe; xx++)
      for (int yy = ay0; yy < ye; yy++) begin
        c = (am == 0) ? ac : (am == 1) ? xx % 8 : (am == 2) ? yy % 8 :
            (((xx + yy) % 2) ? (~ac & 7) : ac);
        exp_q.push_back((xx << 10) | (yy << 3) | c);
      end
  endtask

  task automatic run(input int ax0, ay0, aw, ah, am, ac, input bit hold5, input int rst_at);
    int idx = 0, budget, n;
    bit p;
    model(ax0, ay0, aw, ah, am, ac);
    n = exp_q.size();
    @(negedge clk);
    x0 = ax0[7:0]; y0 = ay0[6:0]; w = aw[7:0]; h = ah[6:0]; mode = am[1:0]; colour = ac[2:0];
    start = 1;
    @(negedge clk);
    x0 = $urandom; y0 = $urandom; w = $urandom; h = $urandom; mode = $urandom; colour = $urandom;
    check("busy_after_start", busy, n != 0);
    check("done_after_start", done, 0);
    check("plot_after_start", vga_plot, 0);
    budget = n * 4 + 10;
    while (idx < n && budget > 0) begin
      pause = pause_en && ($urandom_range(0, 3) == 0);
      p = pause;
      @(negedge clk);
      budget--;
      if (p) begin
        check("paused_plot", vga_plot, 0);
        check("paused_busy", busy, 1);
      end else begin
        check("plot", vga_plot, 1);
        check("pixel", obs(), exp_q[idx]);
        check("busy", busy, idx + 1 < n);
        idx++;
        if (rst_at > 0 && idx == rst_at) begin
          rst = 1;
          @(negedge clk);
          check("rst_pixel", obs(), 0);
          check("rst_plot", vga_plot, 0);
          check("rst_done", done, 0);
          check("rst_busy", busy, 0);
          rst = 0; start = 0; pause = 0;
          return;
        end
      end
    end
    pause = 0;
    check("plot_count", idx, n);
    @(negedge clk);
    check("done_rise", done, 1);
    check("done_plot", vga_plot, 0);
    check("done_busy", busy, 0);
    if (n > 0) check("held_pixel", obs(), exp_q[n-1]);
    repeat (hold5 ? 5 : $urandom_range(0, 2)) begin
      @(negedge clk);
      check("done_hold", done, 1);
    end
    start = 0;
    @(negedge clk);
    @(negedge clk);
    check("done_fall", done, 0);
    check("idle_busy", busy, 0);
    if (n > 0) check("idle_pixel", obs(), exp_q[n-1]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rx, ry, rw, rh;
`ifdef RECT_FILL_PAUSE_EN
    pause_en = 1;
`else
    pause_en = 0;
`endif
    repeat (2) @(negedge clk);
    check("reset_pixel", obs(), 0);
    check("reset_plot", vga_plot, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    rst = 0;
    run(0, 0, 160, 120, 1, 0, 0, 0);
    run(10, 20, 3, 2, 0, 5, 0, 0);
    run(158, 118, 5, 5, 3, 2, 0, 0);
    run(5, 5, 0, 4, 2, 1, 1, 0);
    run(165, 5, 4, 4, 0, 3, 0, 0);
    run(5, 125, 4, 4, 0, 3, 0, 0);
    run(0, 0, 160, 120, 1, 0, 0, 50);
    run(7, 9, 4, 3, 2, 6, 0, 0);
    run(100, 100, 255, 127, 3, 5, 0, 0);
    repeat (40) begin
      rx = $urandom_range(0, 170);
      ry = $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0) begin
        rw = $urandom_range(0, 255);
        rh = $urandom_range(0, 6);
      end else begin
        rw = $urandom_range(0, 12);
        rh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
      end
      run(rx, ry, rw, rh, $urandom_range(0, 3), $urandom_range(0, 7), 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
